reg_dump_reader: RTL and testbench

Sequential read-side scanner for the 32×32 MIPS general-purpose register file. On a start pulse it walks every register address through one asynchronous read port and captures each word. It streams the words out as (address, data) beats over a valid/ready interface. It serves the debug/trace path and testbench dumps, so register state can be observed without halting the datapath's own read ports.

---
 rtl/reg_dump_reader.sv | 198 +++++++++++++++++++
 tb/tb_reg_dump_reader.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump_reader.sv
`default_nettype none
// ============================================================================
// Module   : reg_dump_reader
// Purpose  : Sequential read-side scanner for the general-purpose register
//            file. When it receives a start pulse it walks addresses
//            0..NUM_REGS-1 through one asynchronous read port. It captures
//            each word and streams it out as an (address, data) beat over a
//            valid/ready interface. The datapath's own read ports stay free.
// Options  : REG_DUMP_CHECKSUM_EN - when defined, adds one trailing beat
//            (addr 0, data = XOR of all captured words) after the last
//            register beat.
// Ports    : clk, rst_n      - clock, synchronous active-low reset
//            start          - begin a dump (sampled only when idle)
//            busy, done     - dump in progress / one-cycle completion pulse
//            rf_addr        - registered read address to the register file
//            rf_data        - asynchronous read data for rf_addr
//            out_valid/out_ready/out_addr/out_data/out_last - beat stream
// Revision : 1.0 - initial release
// ============================================================================
module reg_dump_reader #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  localparam logic [ADDR_W-1:0] c_last_idx = ADDR_W'(NUM_REGS - 1);

`ifdef REG_DUMP_CHECKSUM_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_SEND = 2'd2,
    ST_CSUM = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_SEND = 2'd2
  } state_t;
`endif

  state_t              r_state,     w_state_nxt;
  logic                r_busy,      w_busy_nxt;
  logic                r_done,      w_done_nxt;
  logic [ADDR_W-1:0]   r_idx,       w_idx_nxt;    // doubles as rf_addr
  logic                r_out_valid, w_out_valid_nxt;
  logic                r_out_last,  w_out_last_nxt;
  logic [ADDR_W-1:0]   r_out_addr,  w_out_addr_nxt;
  logic [DATA_W-1:0]   r_out_data,  w_out_data_nxt;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0]   r_csum,      w_csum_nxt;
`endif

  logic w_handshake;
  logic w_at_last;

  assign w_handshake = r_out_valid & out_ready;
  assign w_at_last   = (r_idx == c_last_idx);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_idx       <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_addr  <= '0;
      r_out_data  <= '0;
`ifdef REG_DUMP_CHECKSUM_EN
      r_csum      <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_idx       <= w_idx_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_last  <= w_out_last_nxt;
      r_out_addr  <= w_out_addr_nxt;
      r_out_data  <= w_out_data_nxt;
`ifdef REG_DUMP_CHECKSUM_EN
      r_csum      <= w_csum_nxt;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and datapath logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt     = r_state;
    w_busy_nxt      = r_busy;
    w_done_nxt      = 1'b0;           // done is a single-cycle pulse
    w_idx_nxt       = r_idx;
    w_out_valid_nxt = r_out_valid;
    w_out_last_nxt  = r_out_last;
    w_out_addr_nxt  = r_out_addr;
    w_out_data_nxt  = r_out_data;
`ifdef REG_DUMP_CHECKSUM_EN
    w_csum_nxt      = r_csum;
`endif

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_idx_nxt   = '0;
          w_busy_nxt  = 1'b1;
          w_state_nxt = ST_READ;
`ifdef REG_DUMP_CHECKSUM_EN
          w_csum_nxt  = '0;
`endif
        end
      end

      // rf_addr has been stable for a full cycle, so rf_data is valid here.
      ST_READ: begin
        w_out_data_nxt  = rf_data;
        w_out_addr_nxt  = r_idx;
        w_out_valid_nxt = 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
        w_out_last_nxt  = 1'b0;       // the checksum beat is the last one
        w_csum_nxt      = r_csum ^ rf_data;
`else
        w_out_last_nxt  = w_at_last;
`endif
        w_state_nxt     = ST_READ == r_state ? ST_SEND : r_state;
      end

      ST_SEND: begin
        if (w_handshake) begin
          if (!w_at_last) begin
            w_out_valid_nxt = 1'b0;
            w_idx_nxt       = r_idx + ADDR_W'(1);
            w_state_nxt     = ST_READ;
          end else begin
`ifdef REG_DUMP_CHECKSUM_EN
            // Checksum is complete (last word folded in during READ), so the
            // trailing beat can be presented on the very next cycle.
            w_out_valid_nxt = 1'b1;
            w_out_addr_nxt  = '0;
            w_out_data_nxt  = r_csum;
            w_out_last_nxt  = 1'b1;
            w_state_nxt     = ST_CSUM;
`else
            w_out_valid_nxt = 1'b0;
            w_busy_nxt      = 1'b0;
            w_done_nxt      = 1'b1;
            w_state_nxt     = ST_IDLE;
`endif
          end
        end
      end

`ifdef REG_DUMP_CHECKSUM_EN
      ST_CSUM: begin
        if (w_handshake) begin
          w_out_valid_nxt = 1'b0;
          w_busy_nxt      = 1'b0;
          w_done_nxt      = 1'b1;
          w_state_nxt     = ST_IDLE;
        end
      end
`endif

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign rf_addr   = r_idx;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign out_addr  = r_out_addr;
  assign out_data  = r_out_data;

endmodule
`default_nettype wire

// File: tb/tb_reg_dump_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_dump_reader
// Purpose  : Directed self-checking bench for reg_dump_reader. It covers
//            reset, a full dump with cycle timing, backpressure, start
//            handling, a mid-dump reset, a live write and the checksum
//            pattern. When REG_DUMP_CHECKSUM_EN is defined, the bench expects
//            the extra checksum beat.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_dump_reader;

  localparam int NR = 32;
  localparam int AW = 5;
  localparam int DW = 32;
`ifdef REG_DUMP_CHECKSUM_EN
  localparam bit HAS_CSUM = 1'b1;
`else
  localparam bit HAS_CSUM = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          out_ready = 1'b1;
  logic          busy, done, out_valid, out_last;
  logic [AW-1:0] rf_addr, out_addr;
  logic [DW-1:0] rf_data, out_data;

  logic [DW-1:0] rf    [NR];
  logic [DW-1:0] exp_d [NR];

  assign rf_data = rf[rf_addr];

  reg_dump_reader #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .rf_addr  (rf_addr),
    .rf_data  (rf_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_addr (out_addr),
    .out_data (out_data),
    .out_last (out_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_inc();
    for (int i = 0; i < NR; i++) begin
      rf[i]    = 32'h100 + i;
      exp_d[i] = 32'h100 + i;
    end
  endtask

  // Runs one dump to completion and checks every beat.
  //   bp_at  : beat index held off for 5 cycles (-1 = none)
  //   st_at  : beat index at which a stray start is pulsed (-1 = none)
  //   wr_at  : beat index at which rf[NR-1] is rewritten (-1 = none)
  task automatic run_dump(input string tag, input bit do_start, input bit chk_time,
                          input int bp_at, input int st_at, input int wr_at,
                          input bit restart_on_done);
    int            c, beat, stall, hs_cyc, n_exp;
    bit            seen, got_done;
    logic [DW-1:0] csum;
    n_exp    = HAS_CSUM ? NR + 1 : NR;
    beat     = 0;
    stall    = 0;
    hs_cyc   = 0;
    seen     = 1'b0;
    got_done = 1'b0;
    csum     = '0;
    for (int i = 0; i < NR; i++) csum ^= exp_d[i];
    out_ready = 1'b1;
    if (do_start) begin
      start = 1'b1;
      c = cyc;
      @(negedge clk);
      start = 1'b0;
      check({tag, " busy after start"}, busy, 1);
      check({tag, " rf_addr after start"}, rf_addr, 0);
      check({tag, " valid after start"}, out_valid, 0);
    end else begin
      c = cyc - 1;
    end
    for (int t = 0; t < 400 && !got_done; t++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        got_done = 1'b1;
        check({tag, " beat count"}, beat, n_exp);
        check({tag, " busy at done"}, busy, 0);
        if (chk_time) check({tag, " done cycle"}, cyc - c, HAS_CSUM ? 2*NR + 2 : 2*NR + 1);
        if (restart_on_done) start = 1'b1;
      end else if (out_valid) begin
        if (!seen) begin
          seen = 1'b1;
          if (beat < NR) begin
            check({tag, " addr"}, out_addr, beat);
            check({tag, " data"}, out_data, exp_d[beat]);
            check({tag, " last"}, out_last, (beat == NR-1) && !HAS_CSUM);
            if (beat > 0) check({tag, " beat gap"}, cyc - hs_cyc, 2);
            else if (chk_time) check({tag, " first beat cycle"}, cyc - c, 2);
            if (chk_time && beat == NR-1) check({tag, " last beat cycle"}, cyc - c, 2*NR);
          end else begin
            check({tag, " csum addr"}, out_addr, 0);
            check({tag, " csum data"}, out_data, csum);
            check({tag, " csum last"}, out_last, 1);
            check({tag, " csum gap"}, cyc - hs_cyc, 1);
          end
          if (beat == bp_at) stall = 5;
          if (beat == st_at) start = 1'b1;
          if (beat == wr_at) rf[NR-1] = 32'hDEADBEEF;
        end else if (beat < NR) begin
          check({tag, " held addr"}, out_addr, beat);
          check({tag, " held data"}, out_data, exp_d[beat]);
        end
        if (stall > 0) begin
          out_ready = 1'b0;
          stall--;
        end else begin
          out_ready = 1'b1;
          hs_cyc = cyc;
          beat++;
          seen = 1'b0;
        end
      end else if (seen) begin
        check({tag, " valid held"}, out_valid, 1);
      end
    end
    if (!got_done) check({tag, " done timeout"}, got_done, 1);
    @(negedge clk);
    start = 1'b0;
    check({tag, " done one cycle"}, done, 0);
    check({tag, " busy after done"}, busy, restart_on_done);
  endtask

  initial begin
    int n_done;
    bit found;
    for (int i = 0; i < NR; i++) begin
      rf[i]    = '0;
      exp_d[i] = '0;
    end

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst valid", out_valid, 0);
    check("rst last", out_last, 0);
    check("rst rf_addr", rf_addr, 0);
    check("rst out_addr", out_addr, 0);
    check("rst out_data", out_data, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1. Full dump, ready held high
    fill_inc();
    run_dump("full", 1'b1, 1'b1, -1, -1, -1, 1'b0);
    repeat (2) @(negedge clk);

    // 2. Backpressure on beat 3
    run_dump("bp", 1'b1, 1'b0, 3, -1, -1, 1'b0);
    repeat (2) @(negedge clk);

    // 3a. Stray start at beat 7 is ignored
    run_dump("start_ign", 1'b1, 1'b1, -1, 7, -1, 1'b0);
    // 3b. Start during the done cycle launches a second dump
    run_dump("start_done", 1'b1, 1'b1, -1, -1, -1, 1'b1);
    run_dump("second", 1'b0, 1'b1, -1, -1, -1, 1'b0);
    repeat (2) @(negedge clk);

    // 4. Reset during beat 10
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int t = 0; t < 100 && !found; t++) begin
      @(negedge clk);
      if (out_valid && out_addr == 10) found = 1'b1;
    end
    check("rst_mid beat10 reached", found, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_mid busy", busy, 0);
    check("rst_mid valid", out_valid, 0);
    check("rst_mid last", out_last, 0);
    check("rst_mid data", out_data, 0);
    n_done = 0;
    for (int t = 0; t < 80; t++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("rst_mid no done", n_done, 0);
    check("rst_mid idle", busy, 0);
    run_dump("after_rst", 1'b1, 1'b1, -1, -1, -1, 1'b0);
    repeat (2) @(negedge clk);

    // 5. Live write to r[31] during beat 5
    fill_inc();
    exp_d[NR-1] = 32'hDEADBEEF;
    run_dump("live_wr", 1'b1, 1'b1, -1, -1, 5, 1'b0);
    repeat (2) @(negedge clk);

    // 6. Walking-one pattern; checksum beat (if present) is 0xFFFFFFFF
    for (int i = 0; i < NR; i++) begin
      rf[i]    = 32'h1 << i;
      exp_d[i] = 32'h1 << i;
    end
    run_dump("csum", 1'b1, 1'b1, -1, -1, -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
